// File: rtl/spart_baud_gen.sv
// SPART baud generator: tx_tick once per bit period, OVS rx_ticks per period aligned to tx_tick.
// Optional fractional divisor accumulator enabled by defining SPART_BAUD_FRAC_EN.
module spart_baud_gen #(
  parameter int               DIV_W   = 16,
  parameter int               OVS     = 16,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(16'h028B),
  parameter int               FRAC_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         wr,
  input  logic [$clog2(DIV_W/8)-1:0]   sel,
  input  logic [7:0]                   data_in,
  input  logic                         commit,
`ifdef SPART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0]            frac_in,
`endif
  output logic                         tx_tick,
  output logic                         rx_tick,
  output logic                         ready,
  output logic                         pending
);

  localparam int               LANES   = DIV_W / 8;
  localparam int               SEL_W   = $clog2(LANES);
  localparam int               LOG_OVS = $clog2(OVS);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] OVS_D   = DIV_W'(OVS);
  localparam logic [LOG_OVS-1:0] K_LAST = LOG_OVS'(OVS - 1);

  if ((DIV_W % 8) != 0 || DIV_W < 16 || DIV_W > 32) begin : g_bad_div_w
    $error("spart_baud_gen: DIV_W must be a multiple of 8 in 16..32");
  end
  if (OVS < 2 || OVS > 64 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
    $error("spart_baud_gen: OVS must be a power of 2 in 2..64");
  end
  if (FRAC_W < 1) begin : g_bad_frac_w
    $error("spart_baud_gen: FRAC_W must be at least 1");
  end

  logic [DIV_W-1:0]   shadow_reg, shadow_next;
  logic [DIV_W-1:0]   act_div_reg, act_div_next;
  logic [DIV_W-1:0]   nxt_div_reg, nxt_div_next;
  logic               pending_reg, pending_next;
  logic [DIV_W-1:0]   tx_cnt_reg, tx_cnt_next;
  logic [DIV_W-1:0]   rx_cnt_reg, rx_cnt_next;
  logic [LOG_OVS-1:0] k_reg, k_next, k_inc;
  logic               ready_reg, ready_next;
  logic               tx_tick_reg, tx_tick_next;
  logic               rx_tick_reg, rx_tick_next;
  logic               load, load_carry, extra_cur;
  logic [DIV_W-1:0]   load_div;

`ifdef SPART_BAUD_FRAC_EN
  logic [FRAC_W-1:0]  frac_act_reg, frac_act_next;
  logic [FRAC_W-1:0]  nxt_frac_reg, nxt_frac_next;
  logic [FRAC_W-1:0]  acc_reg, acc_next;
  logic               extra_reg, extra_next;
  assign extra_cur = extra_reg;
`else
  assign extra_cur = 1'b0;
`endif

  // Out-of-range lane selects match no lane and leave the shadow untouched.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign shadow_next[8*gi +: 8] = (wr && sel == SEL_W'(gi)) ? data_in : shadow_reg[8*gi +: 8];
  end

  // Sub-period k is q+1 cycles for k < r, else q; the fractional extra cycle lands on the last one.
  function automatic logic [DIV_W-1:0] sub_len(input logic [DIV_W-1:0] div,
                                               input logic [LOG_OVS-1:0] k,
                                               input logic extra);
    logic [LOG_OVS-1:0] r;
    logic [DIV_W-1:0]   len;
    r   = div[LOG_OVS-1:0];
    len = (div >> LOG_OVS) + {{(DIV_W-1){1'b0}}, (k < r)};
    if (k == K_LAST && extra) len = len + ONE;
    return len;
  endfunction

  assign k_inc = k_reg + LOG_OVS'(1);

  always_comb begin
    act_div_next = act_div_reg;
    nxt_div_next = nxt_div_reg;
    pending_next = pending_reg;
    tx_cnt_next  = tx_cnt_reg;
    rx_cnt_next  = rx_cnt_reg;
    k_next       = k_reg;
    ready_next   = ready_reg;
    tx_tick_next = 1'b0;
    rx_tick_next = 1'b0;
    load         = 1'b0;
    load_carry   = 1'b0;
    load_div     = pending_reg ? nxt_div_reg : act_div_reg;
`ifdef SPART_BAUD_FRAC_EN
    frac_act_next = frac_act_reg;
    nxt_frac_next = nxt_frac_reg;
    acc_next      = acc_reg;
    extra_next    = extra_reg;
`endif

    if (!en) begin
      tx_cnt_next = '0;
      rx_cnt_next = '0;
      k_next      = '0;
      ready_next  = 1'b0;
      if (pending_reg) begin
        act_div_next = nxt_div_reg;
        pending_next = 1'b0;
      end
`ifdef SPART_BAUD_FRAC_EN
      if (pending_reg) frac_act_next = nxt_frac_reg;
      acc_next   = '0;
      extra_next = 1'b0;
`endif
    end else if (!ready_reg || tx_cnt_reg == '0) begin
      // Period wrap (or idle start attempt): the tx reload is the only place a commit lands.
      tx_tick_next = ready_reg;
      rx_tick_next = ready_reg;
      load         = 1'b1;
    end else begin
      tx_cnt_next = tx_cnt_reg - ONE;
      if (rx_cnt_reg == '0) begin
        rx_tick_next = 1'b1;
        k_next       = k_inc;
        rx_cnt_next  = sub_len(act_div_reg, k_inc, extra_cur) - ONE;
      end else begin
        rx_cnt_next = rx_cnt_reg - ONE;
      end
    end

    if (load) begin
      act_div_next = load_div;
      pending_next = 1'b0;
      k_next       = '0;
`ifdef SPART_BAUD_FRAC_EN
      if (pending_reg) frac_act_next = nxt_frac_reg;
`endif
      if (load_div >= OVS_D) begin
`ifdef SPART_BAUD_FRAC_EN
        if (pending_reg) acc_next = '0;
        else {load_carry, acc_next} = {1'b0, acc_reg} + {1'b0, frac_act_reg};
        extra_next = load_carry;
`endif
        ready_next  = 1'b1;
        tx_cnt_next = load_div - ONE + {{(DIV_W-1){1'b0}}, load_carry};
        rx_cnt_next = sub_len(load_div, '0, 1'b0) - ONE;
      end else begin
        ready_next  = 1'b0;
        tx_cnt_next = '0;
        rx_cnt_next = '0;
`ifdef SPART_BAUD_FRAC_EN
        acc_next   = '0;
        extra_next = 1'b0;
`endif
      end
    end

    // Snapshot uses the pre-edge shadow; a same-cycle write is not included.
    if (commit) begin
      nxt_div_next = shadow_reg;
      pending_next = 1'b1;
`ifdef SPART_BAUD_FRAC_EN
      nxt_frac_next = frac_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg  <= RST_DIV;
      act_div_reg <= RST_DIV;
      nxt_div_reg <= RST_DIV;
      pending_reg <= 1'b0;
      tx_cnt_reg  <= '0;
      rx_cnt_reg  <= '0;
      k_reg       <= '0;
      ready_reg   <= 1'b0;
      tx_tick_reg <= 1'b0;
      rx_tick_reg <= 1'b0;
`ifdef SPART_BAUD_FRAC_EN
      frac_act_reg <= '0;
      nxt_frac_reg <= '0;
      acc_reg      <= '0;
      extra_reg    <= 1'b0;
`endif
    end else begin
      shadow_reg  <= shadow_next;
      act_div_reg <= act_div_next;
      nxt_div_reg <= nxt_div_next;
      pending_reg <= pending_next;
      tx_cnt_reg  <= tx_cnt_next;
      rx_cnt_reg  <= rx_cnt_next;
      k_reg       <= k_next;
      ready_reg   <= ready_next;
      tx_tick_reg <= tx_tick_next;
      rx_tick_reg <= rx_tick_next;
`ifdef SPART_BAUD_FRAC_EN
      frac_act_reg <= frac_act_next;
      nxt_frac_reg <= nxt_frac_next;
      acc_reg      <= acc_next;
      extra_reg    <= extra_next;
`endif
    end
  end

  assign tx_tick = tx_tick_reg;
  assign rx_tick = rx_tick_reg;
  assign ready   = ready_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_spart_baud_gen.sv
// Scoreboard bench for spart_baud_gen (default build): expected tick cycles are queued
// when stimulus is applied and compared against the observed tick cycles.
module tb_spart_baud_gen;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, wr = 1'b0, commit = 1'b0;
  logic [0:0] sel = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_tick, rx_tick, ready, pending;
  int         cyc = 0, checks = 0, failures = 0;
  int         obs_tx[$], obs_rx[$], exp_tx[$], exp_rx[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spart_baud_gen dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .sel(sel), .data_in(data_in), .commit(commit),
    .tx_tick(tx_tick), .rx_tick(rx_tick), .ready(ready), .pending(pending)
  );

  // Step n falling edges, logging the posedge count at which each tick was registered.
  task automatic collect(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tx_tick) obs_tx.push_back(cyc);
      if (rx_tick) obs_rx.push_back(cyc);
    end
  endtask

  task automatic drive(input logic w, input logic s, input logic [7:0] d, input logic c);
    wr = w; sel = s; data_in = d; commit = c;
    collect(1);
    wr = 1'b0; commit = 1'b0;
  endtask

  // Queue one 651-clk period: 11 sub-periods of 41, then 5 of 40.
  task automatic push_651(input int base, input int nsub);
    int acc = 0;
    for (int k = 0; k < nsub; k++) begin
      acc += (k < 11) ? 41 : 40;
      exp_rx.push_back(base + acc);
    end
    if (nsub == 16) exp_tx.push_back(base + 651);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx_tick !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b exp=0", tx_tick); end
    if (rx_tick !== 1'b0) begin failures++; $display("FAIL reset_rx got=%b exp=0", rx_tick); end
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    rst = 1'b0;
    collect(4);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", ready); end
    $display("test_reset done");
  endtask

  task automatic test_default_rate();
    int t0, got, want;
    obs_tx.delete(); obs_rx.delete();
    en = 1'b1;
    t0 = cyc + 1;
    push_651(t0, 16);
    push_651(t0 + 651, 16);
    collect(1303);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL default_ready got=%b exp=1", ready); end
    checks += 2;
    if (obs_tx.size() != exp_tx.size()) begin failures++; $display("FAIL default_tx_count got=%0d exp=%0d", obs_tx.size(), exp_tx.size()); end
    if (obs_rx.size() != exp_rx.size()) begin failures++; $display("FAIL default_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      got = obs_tx.pop_front(); want = exp_tx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL default_tx_cycle got=%0d exp=%0d", got, want); end
    end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      got = obs_rx.pop_front(); want = exp_rx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL default_rx_cycle got=%0d exp=%0d", got, want); end
    end
    exp_tx.delete(); exp_rx.delete();
    $display("test_default_rate done");
  endtask

  task automatic test_rate_change();
    int b, got, want;
    obs_tx.delete(); obs_rx.delete();
    b = cyc;
    push_651(b, 16);
    exp_tx.push_back(b + 651 + 32);
    exp_tx.push_back(b + 651 + 64);
    for (int j = 1; j <= 32; j++) exp_rx.push_back(b + 651 + 2 * j);
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h20, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL change_pending_set got=%b exp=1", pending); end
    collect(712);
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL change_pending_clr got=%b exp=0", pending); end
    checks += 2;
    if (obs_tx.size() != exp_tx.size()) begin failures++; $display("FAIL change_tx_count got=%0d exp=%0d", obs_tx.size(), exp_tx.size()); end
    if (obs_rx.size() != exp_rx.size()) begin failures++; $display("FAIL change_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      got = obs_tx.pop_front(); want = exp_tx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL change_tx_cycle got=%0d exp=%0d", got, want); end
    end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      got = obs_rx.pop_front(); want = exp_rx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL change_rx_cycle got=%0d exp=%0d", got, want); end
    end
    exp_tx.delete(); exp_rx.delete();
    $display("test_rate_change done");
  endtask

  task automatic test_invalid_div();
    int b, t0, got, want;
    obs_tx.delete(); obs_rx.delete();
    b = cyc;
    exp_tx.push_back(b + 32);
    for (int j = 1; j <= 16; j++) exp_rx.push_back(b + 2 * j);
    drive(1'b1, 1'b0, 8'h0A, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    collect(38);
    checks += 2;
    if (ready !== 1'b0) begin failures++; $display("FAIL invalid_ready got=%b exp=0", ready); end
    if (pending !== 1'b0) begin failures++; $display("FAIL invalid_pending got=%b exp=0", pending); end
    drive(1'b1, 1'b0, 8'h20, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL revalid_ready_early got=%b exp=0", ready); end
    collect(1);
    t0 = cyc;
    checks += 2;
    if (ready !== 1'b1) begin failures++; $display("FAIL revalid_ready got=%b exp=1", ready); end
    if (pending !== 1'b0) begin failures++; $display("FAIL revalid_pending got=%b exp=0", pending); end
    exp_tx.push_back(t0 + 32);
    exp_tx.push_back(t0 + 64);
    for (int j = 1; j <= 32; j++) exp_rx.push_back(t0 + 2 * j);
    collect(64);
    checks += 2;
    if (obs_tx.size() != exp_tx.size()) begin failures++; $display("FAIL invalid_tx_count got=%0d exp=%0d", obs_tx.size(), exp_tx.size()); end
    if (obs_rx.size() != exp_rx.size()) begin failures++; $display("FAIL invalid_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      got = obs_tx.pop_front(); want = exp_tx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL invalid_tx_cycle got=%0d exp=%0d", got, want); end
    end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      got = obs_rx.pop_front(); want = exp_rx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL invalid_rx_cycle got=%0d exp=%0d", got, want); end
    end
    exp_tx.delete(); exp_rx.delete();
    $display("test_invalid_div done");
  endtask

  task automatic test_async_reset();
    int t1, t2, got, want;
    obs_tx.delete(); obs_rx.delete();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", ready); end
    @(negedge clk);
    rst = 1'b0;
    t1 = cyc + 1;
    push_651(t1, 16);
    push_651(t1 + 651, 7);
    collect(939);
    checks++;
    if (rx_tick !== 1'b1) begin failures++; $display("FAIL arst_rx_before got=%b exp=1", rx_tick); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (rx_tick !== 1'b0) begin failures++; $display("FAIL arst_rx_after got=%b exp=0", rx_tick); end
    if (tx_tick !== 1'b0) begin failures++; $display("FAIL arst_tx_after got=%b exp=0", tx_tick); end
    if (ready !== 1'b0) begin failures++; $display("FAIL arst_ready_mid got=%b exp=0", ready); end
    @(negedge clk);
    rst = 1'b0;
    t2 = cyc + 1;
    push_651(t2, 16);
    collect(652);
    checks += 2;
    if (obs_tx.size() != exp_tx.size()) begin failures++; $display("FAIL arst_tx_count got=%0d exp=%0d", obs_tx.size(), exp_tx.size()); end
    if (obs_rx.size() != exp_rx.size()) begin failures++; $display("FAIL arst_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      got = obs_tx.pop_front(); want = exp_tx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL arst_tx_cycle got=%0d exp=%0d", got, want); end
    end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      got = obs_rx.pop_front(); want = exp_rx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL arst_rx_cycle got=%0d exp=%0d", got, want); end
    end
    exp_tx.delete(); exp_rx.delete();
    $display("test_async_reset done");
  endtask

  task automatic test_en_low_commit();
    int t0, acc, got, want;
    obs_tx.delete(); obs_rx.delete();
    en = 1'b0;
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL enlow_ready got=%b exp=0", ready); end
    // Same-cycle write is excluded from the snapshot: divisor becomes 0x008B = 139.
    drive(1'b1, 1'b0, 8'h40, 1'b1);
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL enlow_pending_set got=%b exp=1", pending); end
    collect(1);
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL enlow_pending_clr got=%b exp=0", pending); end
    en = 1'b1;
    t0 = cyc + 1;
    for (int p = 0; p < 2; p++) begin
      acc = 0;
      for (int k = 0; k < 16; k++) begin
        acc += (k < 11) ? 9 : 8;
        exp_rx.push_back(t0 + 139 * p + acc);
      end
      exp_tx.push_back(t0 + 139 * (p + 1));
    end
    collect(279);
    en = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    checks += 2;
    if (pending !== 1'b1) begin failures++; $display("FAIL enlow2_pending_set got=%b exp=1", pending); end
    if (ready !== 1'b0) begin failures++; $display("FAIL enlow2_ready got=%b exp=0", ready); end
    collect(1);
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL enlow2_pending_clr got=%b exp=0", pending); end
    en = 1'b1;
    t0 = cyc + 1;
    exp_tx.push_back(t0 + 64);
    exp_tx.push_back(t0 + 128);
    for (int j = 1; j <= 32; j++) exp_rx.push_back(t0 + 4 * j);
    collect(129);
    checks += 2;
    if (obs_tx.size() != exp_tx.size()) begin failures++; $display("FAIL enlow_tx_count got=%0d exp=%0d", obs_tx.size(), exp_tx.size()); end
    if (obs_rx.size() != exp_rx.size()) begin failures++; $display("FAIL enlow_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      got = obs_tx.pop_front(); want = exp_tx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL enlow_tx_cycle got=%0d exp=%0d", got, want); end
    end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      got = obs_rx.pop_front(); want = exp_rx.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL enlow_rx_cycle got=%0d exp=%0d", got, want); end
    end
    exp_tx.delete(); exp_rx.delete();
    $display("test_en_low_commit done");
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_rate_change();
    test_invalid_div();
    test_async_reset();
    test_en_low_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
